// File: rtl/stl_pkg.sv
// -----------------------------------------------------------------------------
// stl_pkg
// Shared definitions for the serial-to-TileLink path: sequencer state
// encoding, the default serialized packet width and the error marker byte
// placed in the low byte of a timed-out response.
// -----------------------------------------------------------------------------
package stl_pkg;

    // Width of one serialized TileLink packet (16 bytes).
    localparam int STL_PACKET_BITS = 128;

    // Low byte of a synthesized error response.
    localparam logic [7:0] STL_ERR_MARKER = 8'hFF;

    // Sequencer states. The encoding is visible on debug_state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } stl_state_e;

endpackage

// File: rtl/stl_sat_counter.sv
// -----------------------------------------------------------------------------
// stl_sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk      clock
//   reset    synchronous active-high clear
//   inc_i    increment request; ignored once the count is all-ones
//   count_o  current count
// -----------------------------------------------------------------------------
module stl_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        // Hold at all-ones instead of wrapping back to zero.
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/stl_txn_sequencer.sv
// -----------------------------------------------------------------------------
// stl_txn_sequencer
// Single-outstanding transaction sequencer between the UART packet client and
// the UART<->TileLink bridges. A request is latched, issued to the bridge,
// and the bridge response (or a synthesized error packet on timeout) is
// returned to the client.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req_valid/req_ready/req_data      request packet from the client
//   br_valid/br_ready/br_data         request towards the UART-to-TL bridge
//   bresp_valid/bresp_ready/bresp_data response from the TL-to-UART bridge
//   rsp_valid/rsp_ready/rsp_data      response packet back to the client
//   busy                              high whenever not IDLE
//   txn_count/timeout_count/stray_count saturating status counters
//   debug_state                       current state encoding
// -----------------------------------------------------------------------------
module stl_txn_sequencer
    import stl_pkg::*;
#(
    parameter int PACKET_BITS    = STL_PACKET_BITS,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [PACKET_BITS-1:0] req_data,

    output logic                   br_valid,
    input  logic                   br_ready,
    output logic [PACKET_BITS-1:0] br_data,

    input  logic                   bresp_valid,
    output logic                   bresp_ready,
    input  logic [PACKET_BITS-1:0] bresp_data,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PACKET_BITS-1:0] rsp_data,

    output logic                   busy,
    output logic [15:0]            txn_count,
    output logic [7:0]             timeout_count,
    output logic [7:0]             stray_count,
    output logic [1:0]             debug_state
);

    // Timer only has to reach TIMEOUT_CYCLES-1.
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    stl_state_e             state_q,     state_d;
    logic [TIMER_W-1:0]     timer_q,     timer_d;
    logic [PACKET_BITS-1:0] req_q,       req_d;
    logic [PACKET_BITS-1:0] rsp_q,       rsp_d;
    logic                   br_valid_q,  br_valid_d;
    logic                   rsp_valid_q, rsp_valid_d;

    logic txn_inc;
    logic timeout_inc;
    logic stray_inc;

    // Next-state logic. The valid outputs get their own flops, updated in
    // step with the state, so no *_ready input reaches a *_valid output.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        req_d       = req_q;
        rsp_d       = rsp_q;
        br_valid_d  = br_valid_q;
        rsp_valid_d = rsp_valid_q;
        txn_inc     = 1'b0;
        timeout_inc = 1'b0;
        stray_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Nothing is outstanding, so any response is unsolicited.
                stray_inc = bresp_valid;
                if (req_valid) begin
                    req_d      = req_data;
                    br_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                stray_inc = bresp_valid;
                if (br_ready) begin
                    br_valid_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                // A real response arriving on the terminal cycle beats the timeout.
                if (bresp_valid) begin
                    rsp_d       = bresp_data;
                    rsp_valid_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_RETURN;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_d       = {req_q[PACKET_BITS-1:8], STL_ERR_MARKER};
                    rsp_valid_d = 1'b1;
                    timeout_inc = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_RETURN;
                end
            end

            ST_RETURN: begin
                // Late response for an already timed-out request lands here.
                stray_inc = bresp_valid;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_inc     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                br_valid_d  = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            req_q       <= '0;
            rsp_q       <= '0;
            br_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            br_valid_q  <= br_valid_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    stl_sat_counter #(.WIDTH(16)) u_txn_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (txn_inc),
        .count_o (txn_count)
    );

    stl_sat_counter #(.WIDTH(8)) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (timeout_inc),
        .count_o (timeout_count)
    );

    stl_sat_counter #(.WIDTH(8)) u_stray_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stray_inc),
        .count_o (stray_count)
    );

    assign req_ready   = (state_q == ST_IDLE);
    assign br_valid    = br_valid_q;
    assign br_data     = req_q;
    // Responses are always accepted; out-of-WAIT ones are dropped and counted.
    assign bresp_ready = 1'b1;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_q;
    assign busy        = (state_q != ST_IDLE);
    assign debug_state = state_q;

endmodule

// File: tb/tb_stl_txn_sequencer.sv
module tb_stl_txn_sequencer;

    localparam int PB = 128;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [PB-1:0] req_data;
    logic          br_valid, br_ready;
    logic [PB-1:0] br_data;
    logic          bresp_valid, bresp_ready;
    logic [PB-1:0] bresp_data;
    logic          rsp_valid, rsp_ready;
    logic [PB-1:0] rsp_data;
    logic          busy;
    logic [15:0]   txn_count;
    logic [7:0]    timeout_count, stray_count;
    logic [1:0]    debug_state;

    stl_txn_sequencer #(.PACKET_BITS(PB), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_data       (br_data),
        .bresp_valid   (bresp_valid),
        .bresp_ready   (bresp_ready),
        .bresp_data    (bresp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .txn_count     (txn_count),
        .timeout_count (timeout_count),
        .stray_count   (stray_count),
        .debug_state   (debug_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench model of the status counters.
    int exp_txn   = 0;
    int exp_to    = 0;
    int exp_stray = 0;

    logic [PB-1:0] sb_q[$];

    typedef struct {
        logic [PB-1:0] req;
        int            br_delay;    // cycles br_ready held low
        int            resp_delay;  // WAIT cycle (timer value) carrying bresp; -1 = none
        logic [PB-1:0] resp;
        int            rsp_delay;   // cycles rsp_ready held low
        logic [PB-1:0] exp_rsp;
        int            exp_lat;     // cycles from br handshake to rsp_valid
        bit            exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_txn_count"},     PB'(txn_count),     PB'(exp_txn));
        chk({tag, "_timeout_count"}, PB'(timeout_count), PB'(exp_to));
        chk({tag, "_stray_count"},   PB'(stray_count),   PB'(exp_stray));
    endtask

    // Scoreboard consumer: every rsp handshake pops one expected packet.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && reset === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp_valid: got rsp_valid=1 rsp_data=%h required rsp_valid=0", rsp_data);
            end else if (rsp_ready === 1'b1) begin
                logic [PB-1:0] e;
                e = sb_q.pop_front();
                chk("rsp_data", rsp_data, e);
            end
        end
    end

    // Runs one full transaction from a table entry. Entered and left at
    // posedge+1 with the DUT in IDLE.
    task automatic do_txn(input int idx, input vec_t v);
        int n;
        int lat;
        req_data  = v.req;
        req_valid = 1'b1;
        @(negedge clk);
        chk("req_ready_at_idle", PB'(req_ready), PB'(1));
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        sb_q.push_back(v.exp_rsp);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = {$urandom, $urandom, $urandom, $urandom};

        // ISSUE with optional back-pressure.
        br_ready = 1'b0;
        repeat (v.br_delay) begin
            @(negedge clk);
            chk("br_valid_hold", PB'(br_valid), PB'(1));
            chk("br_data_hold",  br_data, v.req);
            chk("req_ready_busy", PB'(req_ready), PB'(0));
            @(posedge clk); #1;
        end
        br_ready = 1'b1;
        @(negedge clk);
        chk("br_valid", PB'(br_valid), PB'(1));
        chk("br_data",  br_data, v.req);
        chk("busy_issue", PB'(busy), PB'(1));
        @(posedge clk); #1;
        br_ready = 1'b0;

        // WAIT: drive bresp on the chosen timer value and measure latency.
        lat = 0;
        bresp_data = v.resp;
        while (lat < 40) begin
            bresp_valid = (v.resp_delay == lat);
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        bresp_valid = 1'b0;
        chk("rsp_latency", PB'(lat), PB'(v.exp_lat));
        @(posedge clk); #1;

        // RETURN with optional back-pressure.
        repeat (v.rsp_delay) begin
            @(negedge clk);
            chk("rsp_valid_hold", PB'(rsp_valid), PB'(1));
            chk("rsp_data_hold",  rsp_data, v.exp_rsp);
            chk("req_ready_busy", PB'(req_ready), PB'(0));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sb_q.size() != 0 && n < 50);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_handshake_timeout: got no handshake required one within 50 cycles");
            sb_q.delete();
        end
        rsp_ready = 1'b0;
        exp_txn++;
        if (v.exp_to) exp_to++;
        $display("txn %0d: req=%h rsp=%h lat=%0d timeout=%0d", idx, v.req, rsp_data, lat, v.exp_to);
        chk_counters($sformatf("txn%0d", idx));
    endtask

    task automatic stray_pulse(input string tag);
        bresp_valid = 1'b1;
        bresp_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bresp_valid = 1'b0;
        exp_stray++;
        @(negedge clk);
        chk({tag, "_no_rsp_valid"}, PB'(rsp_valid), PB'(0));
        chk({tag, "_stray_count"},  PB'(stray_count), PB'(exp_stray));
        $display("stray pulse %s: stray_count=%0d", tag, stray_count);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{128'h0123456789ABCDEF0123456789ABCDEF, 0, 5,
                    128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 0,
                    128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 6, 1'b0};
        vecs[1] = '{128'h11112222333344445555666677778899, 0, -1,
                    128'h0, 0,
                    128'h111122223333444455556666777788FF, 16, 1'b1};
        vecs[2] = '{128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D, 0, 15,
                    128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, 0,
                    128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, 16, 1'b0};
        vecs[3] = '{128'h0F0E0D0C0B0A09080706050403020100, 20, 3,
                    128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 20,
                    128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 4, 1'b0};
        vecs[4] = '{128'h1, 0, 0,
                    128'h2, 0,
                    128'h2, 1, 1'b0};
        vecs[5] = '{128'h80000000000000000000000000000001, 2, -1,
                    128'h0, 3,
                    128'h800000000000000000000000000000FF, 16, 1'b1};

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_data    = '0;
        br_ready    = 1'b0;
        bresp_valid = 1'b0;
        bresp_data  = '0;
        rsp_ready   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state",     PB'(debug_state), PB'(0));
        chk("rst_busy",      PB'(busy), PB'(0));
        chk("rst_br_valid",  PB'(br_valid), PB'(0));
        chk("rst_rsp_valid", PB'(rsp_valid), PB'(0));
        chk("rst_br_data",   br_data, PB'(0));
        chk("rst_rsp_data",  rsp_data, PB'(0));
        chk("rst_req_ready", PB'(req_ready), PB'(1));
        chk_counters("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic transaction, stray in IDLE, timeout, stray after timeout.
        do_txn(0, vecs[0]);
        stray_pulse("idle");
        do_txn(1, vecs[1]);
        stray_pulse("post_timeout");
        chk("stray_total_two", PB'(stray_count), PB'(2));

        // Remaining table entries run back to back.
        for (int i = 2; i < 6; i++) begin
            do_txn(i, vecs[i]);
        end

        // Reset in WAIT abandons the transaction; a late response is stray.
        req_data  = 128'hFEEDFACEFEEDFACEFEEDFACEFEEDFACE;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        br_ready  = 1'b1;
        @(posedge clk); #1;
        br_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_state_wait", PB'(debug_state), PB'(2));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_txn = 0; exp_to = 0; exp_stray = 0;
        @(negedge clk);
        chk("mid_rst_state",     PB'(debug_state), PB'(0));
        chk("mid_rst_rsp_valid", PB'(rsp_valid), PB'(0));
        chk("mid_rst_rsp_data",  rsp_data, PB'(0));
        @(posedge clk); #1;
        stray_pulse("after_reset");
        chk_counters("after_reset");
        $display("reset-in-WAIT: state=%0d stray=%0d txn=%0d timeout=%0d",
                 debug_state, stray_count, txn_count, timeout_count);

        // Reset coincident with a request handshake wins.
        req_data  = 128'h1234;
        req_valid = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        exp_stray = 0;
        @(negedge clk);
        chk("rst_vs_hs_state",   PB'(debug_state), PB'(0));
        chk("rst_vs_hs_brvalid", PB'(br_valid), PB'(0));
        chk("rst_vs_hs_brdata",  br_data, PB'(0));
        $display("reset vs handshake: state=%0d br_valid=%0d", debug_state, br_valid);
        @(posedge clk); #1;

        // stray_count saturates at 255.
        bresp_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        bresp_valid = 1'b0;
        @(negedge clk);
        chk("stray_saturate", PB'(stray_count), PB'(255));
        chk("sat_no_rsp",     PB'(rsp_valid), PB'(0));
        $display("saturation: stray_count=%0d", stray_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
